// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid slot, flush and a
// saturating stall counter for back-pressure statistics.
module pipe_stage_reg #(
  parameter int                 WIDTH     = 32,
  parameter int                 SKID      = 1,
  parameter int                 CNT_W     = 16,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       occupancy
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    BOTH  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             ready_q, ready_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             xfer_in, xfer_out;

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  // State, payload slots and registered ready; reset beats flush and handshakes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      main_q  <= main_nxt;
      skid_q  <= skid_nxt;
      ready_q <= ready_nxt;
    end
  end

  // Next-state and slot updates; the skid slot only fills when SKID is enabled.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (xfer_in) begin
          state_nxt = FULL;
          main_nxt  = in_data;
        end
      end
      FULL: begin
        if (xfer_in && xfer_out) begin
          main_nxt = in_data;
        end else if (xfer_in) begin
          if (SKID != 0) begin
            state_nxt = BOTH;
            skid_nxt  = in_data;
          end else begin
            main_nxt = in_data;
          end
        end else if (xfer_out) begin
          state_nxt = EMPTY;
        end
      end
      BOTH: begin
        if (xfer_out) begin
          state_nxt = FULL;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end
    ready_nxt = (state_nxt != BOTH);
  end

  // Outputs; in_ready is held low while reset is asserted.
  always_comb begin
    out_valid = (state != EMPTY);
    out_data  = main_q;
    occupancy = state;
    stall_cnt = cnt_q;
    if (SKID != 0) begin
      in_ready = rst & ready_q;
    end else begin
      in_ready = rst & (~out_valid | out_ready);
    end
  end

  // Saturating stall counter; clear wins over increment, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (stall_clr) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance and one SKID=0 instance.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV1 = 32'hCAFE0000;
  localparam logic [31:0] RV0 = 32'h0000BEEF;

  logic        clk;
  logic        rst;

  logic        flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
  logic [31:0] in_data, out_data;
  logic [3:0]  stall_cnt;
  logic [1:0]  occupancy;

  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, stall_clr0;
  logic [31:0] in_data0, out_data0;
  logic [3:0]  stall_cnt0;
  logic [1:0]  occupancy0;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        stall_clr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ready;
    logic [1:0]  exp_occ;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[17];

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(4), .RESET_VAL(RV1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt), .occupancy(occupancy)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(4), .RESET_VAL(RV0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .stall_clr(stall_clr0), .stall_cnt(stall_cnt0), .occupancy(occupancy0)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic f, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic clr, input logic ev,
                              input logic [31:0] ed, input logic er,
                              input logic [1:0] eo, input logic [3:0] ec);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy; v.stall_clr = clr;
    v.exp_valid = ev; v.exp_data = ed; v.exp_ready = er; v.exp_occ = eo; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic f, input logic iv, input logic [31:0] d,
                               input logic ordy, input logic clr);
    flush = f; in_valid = iv; in_data = d; out_ready = ordy; stall_clr = clr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 32'hA0,   1, 0, 0, 32'h0,  1, 0, 0);
    vecs[1]  = mk(0, 1, 32'hA1,   1, 0, 1, 32'hA0, 1, 1, 0);
    vecs[2]  = mk(0, 1, 32'hA2,   0, 0, 1, 32'hA1, 1, 1, 0);
    vecs[3]  = mk(0, 1, 32'hA3,   0, 0, 1, 32'hA1, 0, 2, 1);
    vecs[4]  = mk(0, 1, 32'hA3,   0, 0, 1, 32'hA1, 0, 2, 2);
    vecs[5]  = mk(0, 1, 32'hA3,   1, 0, 1, 32'hA1, 0, 2, 3);
    vecs[6]  = mk(0, 1, 32'hA3,   1, 0, 1, 32'hA2, 1, 1, 3);
    vecs[7]  = mk(0, 1, 32'hA4,   1, 0, 1, 32'hA3, 1, 1, 3);
    vecs[8]  = mk(0, 1, 32'hA5,   1, 0, 1, 32'hA4, 1, 1, 3);
    vecs[9]  = mk(0, 0, 32'h0,    1, 0, 1, 32'hA5, 1, 1, 3);
    vecs[10] = mk(0, 0, 32'h0,    1, 0, 0, 32'h0,  1, 0, 3);
    vecs[11] = mk(0, 1, 32'hB0,   0, 1, 0, 32'h0,  1, 0, 3);
    vecs[12] = mk(0, 1, 32'hB1,   0, 0, 1, 32'hB0, 1, 1, 0);
    vecs[13] = mk(1, 1, 32'hDEAD, 0, 0, 1, 32'hB0, 0, 2, 1);
    vecs[14] = mk(0, 0, 32'h0,    1, 0, 0, 32'h0,  1, 0, 2);
    vecs[15] = mk(1, 1, 32'hC0,   1, 0, 0, 32'h0,  1, 0, 2);
    vecs[16] = mk(0, 0, 32'h0,    1, 0, 0, 32'h0,  1, 0, 2);

    rst = 1'b0;
    applyStimulus(0, 0, 32'h0, 1, 0);
    flush0 = 0; in_valid0 = 0; in_data0 = 0; out_ready0 = 1; stall_clr0 = 0;

    // Reset for two edges; in_ready must stay low while rst is asserted
    stepCycle();
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_in_ready0", 32'(in_ready0), 32'd0);
    stepCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_rst_out_data", out_data, RV1);
    checkOutput("post_rst_occ", 32'(occupancy), 32'd0);
    checkOutput("post_rst_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("post_rst_in_ready0", 32'(in_ready0), 32'd1);
    checkOutput("post_rst_out_data0", out_data0, RV0);
    stepCycle();

    // SKID=0: combinational ready path and bubble-free replacement
    in_valid0 = 1; in_data0 = 32'h11; out_ready0 = 1;
    @(negedge clk);
    checkOutput("s0_first_valid", 32'(out_valid0), 32'd0);
    checkOutput("s0_first_ready", 32'(in_ready0), 32'd1);
    stepCycle();
    in_valid0 = 1; in_data0 = 32'h22; out_ready0 = 0;
    @(negedge clk);
    checkOutput("s0_held_valid", 32'(out_valid0), 32'd1);
    checkOutput("s0_held_data", out_data0, 32'h11);
    checkOutput("s0_blocked_ready", 32'(in_ready0), 32'd0);
    checkOutput("s0_occ", 32'(occupancy0), 32'd1);
    out_ready0 = 1;
    #1;
    checkOutput("s0_comb_ready", 32'(in_ready0), 32'd1);
    stepCycle();
    in_valid0 = 0; out_ready0 = 0;
    @(negedge clk);
    checkOutput("s0_replace_valid", 32'(out_valid0), 32'd1);
    checkOutput("s0_replace_data", out_data0, 32'h22);
    checkOutput("s0_cnt0", 32'(stall_cnt0), 32'd0);
    stepCycle();
    out_ready0 = 1;
    @(negedge clk);
    checkOutput("s0_cnt1", 32'(stall_cnt0), 32'd1);
    checkOutput("s0_still_data", out_data0, 32'h22);
    stepCycle();
    @(negedge clk);
    checkOutput("s0_drained", 32'(out_valid0), 32'd0);
    checkOutput("s0_drained_occ", 32'(occupancy0), 32'd0);
    stepCycle();

    // SKID=1: stream 1..8 under continuous ready
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, (i < 8), 32'(i + 1), 1, 0);
      @(negedge clk);
      checkOutput($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'((i >= 1) && (i <= 8)));
      if ((i >= 1) && (i <= 8)) checkOutput($sformatf("stream_data_%0d", i), out_data, 32'(i));
      stepCycle();
    end
    @(negedge clk);
    checkOutput("stream_cnt", 32'(stall_cnt), 32'd0);
    stepCycle();

    // SKID=1: back-pressure and flush vectors
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data,
                    vecs[i].out_ready, vecs[i].stall_clr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_cnt));
      stepCycle();
    end

    // Counter saturation: load one beat with the counter cleared, then stall 20 cycles
    applyStimulus(0, 1, 32'h5A, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sat_cnt_%0d", i), 32'(stall_cnt), 32'((i < 15) ? i : 15));
      checkOutput($sformatf("sat_data_%0d", i), out_data, 32'h5A);
      stepCycle();
    end
    @(negedge clk);
    checkOutput("sat_final", 32'(stall_cnt), 32'd15);
    stall_clr = 1;
    stepCycle();
    stall_clr = 0;
    @(negedge clk);
    checkOutput("clr_zero", 32'(stall_cnt), 32'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("clr_resume", 32'(stall_cnt), 32'd1);

    // Reset mid-transfer with both slots full
    applyStimulus(0, 1, 32'h77, 0, 0);
    stepCycle();
    @(negedge clk);
    checkOutput("pre_rst_occ", 32'(occupancy), 32'd2);
    stepCycle();
    rst = 1'b0;
    applyStimulus(0, 1, 32'h88, 1, 0);
    @(negedge clk);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    stepCycle();
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0);
    @(negedge clk);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_data", out_data, RV1);
    checkOutput("mid_rst_occ", 32'(occupancy), 32'd0);
    checkOutput("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_data0", out_data0, RV0);
    stepCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
